// File: rtl/pwm_seq_pkg.sv
// Shared types and defaults for the PWM duty sequencer.
// Build option: PWM_SEQ_WATCHDOG_EN enables the target watchdog.
package pwm_seq_pkg;

    localparam int DW_DEF  = 24;
    localparam int NCH_DEF = 4;

    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CH_IDX_W = ch_idx_w(NCH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN
    } seq_state_e;

endpackage

// File: rtl/pwm_slew_step.sv
// Combinational clamp + slew-limit step for one channel.
// Target is clamped to [duty_min, period]; period wins on conflict.
module pwm_slew_step
    import pwm_seq_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] cur,
    input  logic [DW-1:0] target,
    input  logic [DW-1:0] step,
    input  logic [DW-1:0] duty_min,
    input  logic [DW-1:0] period,
    output logic [DW-1:0] next
);

    logic [DW-1:0] lo;
    logic [DW-1:0] t;
    logic [DW-1:0] diff;

    always_comb begin
        lo   = (target < duty_min) ? duty_min : target;
        t    = (lo > period) ? period : lo;
        diff = (t >= cur) ? (t - cur) : (cur - t);
        if (diff <= step) begin
            next = t;
        end else if (t > cur) begin
            next = cur + step;
        end else begin
            next = cur - step;
        end
    end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Arms, slew-ramps and atomically commits four-channel PWM duties.
// Build option: PWM_SEQ_WATCHDOG_EN adds the target-strobe watchdog.
module pwm_duty_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int DW           = DW_DEF,
    parameter int NCH          = NCH_DEF,
    parameter int ARM_PERIODS  = 50,
    parameter int WDOG_PERIODS = 25
) (
    input  logic              pwm_clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DW-1:0]     period,
    input  logic [DW-1:0]     duty_min,
    input  logic [DW-1:0]     step,
    input  logic [NCH*DW-1:0] target,
    input  logic              target_valid,
    output logic [NCH*DW-1:0] duty_out,
    output logic              duty_upd,
    output logic              armed,
    output logic              fault
);

    localparam int IW = ch_idx_w(NCH);
    localparam int AW = $clog2(ARM_PERIODS + 1);

    typedef logic [NCH-1:0][DW-1:0] duty_vec_t;

    seq_state_e    state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] arm_q, arm_d;
    duty_vec_t     shadow_q, shadow_d;
    duty_vec_t     snap_q, snap_d;
    duty_vec_t     work_q, work_d;
    duty_vec_t     out_q, out_d;
    logic          upd_q, upd_d;
    logic          walk_q, walk_d;
    logic [IW-1:0] idx_q, idx_d;

    logic          tick_ok;
    logic          tick;
    logic [DW-1:0] dmin_c;
    logic [DW-1:0] slew_next;

    // Periods too short to fit the channel walk produce no ticks.
    assign tick_ok = (period >= DW'(NCH + 3));
    assign tick    = tick_ok && (cnt_q >= period - DW'(1));
    assign dmin_c  = (duty_min > period) ? period : duty_min;

    pwm_slew_step #(
        .DW(DW)
    ) u_slew (
        .cur      (work_q[idx_q]),
        .target   (snap_q[idx_q]),
        .step     (step),
        .duty_min (duty_min),
        .period   (period),
        .next     (slew_next)
    );

`ifdef PWM_SEQ_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_PERIODS + 1);
    logic [WW-1:0] wdog_q, wdog_d;
    logic          fault_q, fault_d;
`endif

    always_comb begin
        state_d  = state_q;
        arm_d    = arm_q;
        shadow_d = shadow_q;
        snap_d   = snap_q;
        work_d   = work_q;
        out_d    = out_q;
        upd_d    = 1'b0;
        walk_d   = walk_q;
        idx_d    = idx_q;

        if (!tick_ok || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DW'(1);
        end

        if (target_valid) begin
            shadow_d = target;
        end

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = ST_ARM;
                    arm_d   = '0;
                    out_d   = {NCH{dmin_c}};
                    upd_d   = 1'b1;
                end
            end
            ST_ARM: begin
                if (tick) begin
                    if (arm_q == AW'(ARM_PERIODS - 1)) begin
                        state_d = ST_RUN;
                        work_d  = {NCH{dmin_c}};
                    end else begin
                        arm_d = arm_q + AW'(1);
                    end
                end
            end
            ST_RUN: begin
                if (walk_q) begin
                    work_d[idx_q] = slew_next;
                    idx_d         = idx_q + IW'(1);
                    // Last channel: publish every working duty at once.
                    if (idx_q == IW'(NCH - 1)) begin
                        walk_d = 1'b0;
                        out_d  = work_d;
                        upd_d  = 1'b1;
                    end
                end
                if (tick) begin
                    snap_d = shadow_q;
                    walk_d = 1'b1;
                    idx_d  = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef PWM_SEQ_WATCHDOG_EN
        wdog_d  = wdog_q;
        fault_d = fault_q;
        if (state_q != ST_RUN || target_valid) begin
            wdog_d = '0;
        end else if (tick && !fault_q) begin
            if (wdog_q == WW'(WDOG_PERIODS - 1)) begin
                fault_d = 1'b1;
            end else begin
                wdog_d = wdog_q + WW'(1);
            end
        end
        if (fault_d) begin
            shadow_d = {NCH{duty_min}};
        end
        if (!enable) begin
            fault_d = 1'b0;
        end
`endif

        if (!enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            out_d   = '0;
            upd_d   = |out_q;
            work_d  = '0;
            walk_d  = 1'b0;
        end
    end

    always_ff @(posedge pwm_clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            arm_q    <= '0;
            shadow_q <= '0;
            snap_q   <= '0;
            work_q   <= '0;
            out_q    <= '0;
            upd_q    <= 1'b0;
            walk_q   <= 1'b0;
            idx_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            arm_q    <= arm_d;
            shadow_q <= shadow_d;
            snap_q   <= snap_d;
            work_q   <= work_d;
            out_q    <= out_d;
            upd_q    <= upd_d;
            walk_q   <= walk_d;
            idx_q    <= idx_d;
        end
    end

`ifdef PWM_SEQ_WATCHDOG_EN
    always_ff @(posedge pwm_clk) begin
        if (reset) begin
            wdog_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign duty_out = out_q;
    assign duty_upd = upd_q;
    assign armed    = (state_q == ST_RUN);

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Randomized bench for pwm_duty_sequencer against a per-tick
// behavioural model of arming, slew ramping and delayed commit.
module tb_pwm_duty_sequencer;

    localparam int DW    = 24;
    localparam int NCH   = 4;
    localparam int ARM_P = 3;
    localparam int WD_P  = 2;

    logic              pwm_clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [DW-1:0]     period;
    logic [DW-1:0]     duty_min;
    logic [DW-1:0]     step;
    logic [NCH*DW-1:0] target;
    logic              target_valid;
    logic [NCH*DW-1:0] duty_out;
    logic              duty_upd;
    logic              armed;
    logic              fault;

    int n_chk  = 0;
    int n_pass = 0;

    pwm_duty_sequencer #(
        .DW           (DW),
        .NCH          (NCH),
        .ARM_PERIODS  (ARM_P),
        .WDOG_PERIODS (WD_P)
    ) dut (
        .pwm_clk      (pwm_clk),
        .reset        (reset),
        .enable       (enable),
        .period       (period),
        .duty_min     (duty_min),
        .step         (step),
        .target       (target),
        .target_valid (target_valid),
        .duty_out     (duty_out),
        .duty_upd     (duty_upd),
        .armed        (armed),
        .fault        (fault)
    );

    initial forever #5 pwm_clk = ~pwm_clk;

    // Model: 0 idle, 1 arming, 2 running.
    int          m_st;
    int          m_cnt;
    int          m_arm;
    int          m_pend;
    int unsigned m_sh [NCH];
    int unsigned m_wk [NCH];
    int unsigned m_pv [NCH];
    int unsigned m_out[NCH];
    bit          m_upd;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned slew(input int unsigned cur,
                                         input int unsigned tgt,
                                         input int unsigned stp,
                                         input int unsigned dmin,
                                         input int unsigned per);
        int unsigned t;
        t = (tgt < dmin) ? dmin : tgt;
        if (t > per) t = per;
        if (t > cur) return (t - cur <= stp) ? t : cur + stp;
        return (cur - t <= stp) ? t : cur - stp;
    endfunction

    function automatic bit tick_now();
        return (m_st != 0) && (period >= NCH + 3) &&
               (m_cnt >= int'(period) - 1);
    endfunction

    function automatic logic [NCH*DW-1:0] exp_out();
        logic [NCH*DW-1:0] v;
        for (int i = 0; i < NCH; i++) v[i*DW +: DW] = DW'(m_out[i]);
        return v;
    endfunction

    task automatic model_reset();
        m_st = 0; m_cnt = 0; m_arm = 0; m_pend = -1; m_upd = 0;
        for (int i = 0; i < NCH; i++) begin
            m_sh[i] = 0; m_wk[i] = 0; m_pv[i] = 0; m_out[i] = 0;
        end
    endtask

    task automatic model_step();
        bit          tk;
        int          old_st;
        int unsigned dmc;
        tk     = tick_now();
        old_st = m_st;
        m_upd  = 0;
        if (reset) begin
            model_reset();
            return;
        end
        dmc = (duty_min > period) ? period : duty_min;
        if (!enable) begin
            for (int i = 0; i < NCH; i++) begin
                if (m_out[i] != 0) m_upd = 1;
                m_out[i] = 0;
                m_wk[i]  = 0;
            end
            m_st = 0; m_cnt = 0; m_pend = -1;
        end else begin
            if (m_pend == 0) begin
                m_out  = m_pv;
                m_upd  = 1;
                m_pend = -1;
            end else if (m_pend > 0) begin
                m_pend--;
            end
            case (m_st)
                0: begin
                    m_st = 1; m_arm = 0; m_upd = 1;
                    for (int i = 0; i < NCH; i++) m_out[i] = dmc;
                end
                1: if (tk) begin
                    m_arm++;
                    if (m_arm == ARM_P) begin
                        m_st = 2;
                        for (int i = 0; i < NCH; i++) m_wk[i] = dmc;
                    end
                end
                default: if (tk) begin
                    for (int i = 0; i < NCH; i++)
                        m_wk[i] = slew(m_wk[i], m_sh[i], step,
                                       duty_min, period);
                    m_pv   = m_wk;
                    m_pend = NCH - 1;
                end
            endcase
            if (old_st == 0 || period < NCH + 3 || tk) m_cnt = 0;
            else m_cnt++;
        end
        if (target_valid)
            for (int i = 0; i < NCH; i++) m_sh[i] = target[i*DW +: DW];
    endtask

    task automatic cycle();
        model_step();
        @(posedge pwm_clk);
        #1;
        chk("duty_out", duty_out, exp_out());
        chk("duty_upd", duty_upd, m_upd);
        chk("armed", armed, (m_st == 2));
`ifndef PWM_SEQ_WATCHDOG_EN
        chk("fault", fault, 1'b0);
`endif
        @(negedge pwm_clk);
    endtask

    task automatic run_until_tick();
        int n;
        n = 0;
        while (!tick_now() && n < 3000) begin
            cycle();
            n++;
        end
        if (!tick_now()) chk("tick_timeout", 128'd0, 128'd1);
    endtask

    task automatic tick_cycles(input int n);
        repeat (n) begin
            run_until_tick();
            repeat (NCH + 1) cycle();
        end
    endtask

    initial begin
        reset = 1; enable = 0; target_valid = 0;
        period = 100; duty_min = 10; step = 4; target = '0;
        model_reset();
        @(negedge pwm_clk);
        repeat (3) cycle();
        reset = 0;
        repeat (500) cycle();

        target = {24'd100, 24'd12, 24'd10, 24'd40};
        target_valid = 1;
        cycle();
        target_valid = 0;
        enable = 1;
        cycle();
        chk("arm_duty", duty_out, {NCH{24'd10}});
        for (int n = 0; n < 400 && !armed; n++) cycle();
        chk("armed_reached", armed, 1'b1);

        tick_cycles(26);
        chk("ramp_ch0", duty_out[0*DW +: DW], 24'd40);
        chk("ramp_ch1", duty_out[1*DW +: DW], 24'd10);
        chk("ramp_ch2", duty_out[2*DW +: DW], 24'd12);
        chk("ramp_ch3", duty_out[3*DW +: DW], 24'd100);

        run_until_tick();
        target[DW-1:0] = 24'd50;
        target_valid = 1;
        cycle();
        target_valid = 0;
        repeat (NCH) cycle();
        chk("same_tick_ignored", duty_out[DW-1:0], 24'd40);
        tick_cycles(1);
        chk("same_tick_next", duty_out[DW-1:0], 24'd44);

        target[DW-1:0] = 24'd5;
        target_valid = 1;
        cycle();
        target_valid = 0;
        tick_cycles(12);
        chk("below_min_hold", duty_out[DW-1:0], 24'd10);

        run_until_tick();
        cycle();
        cycle();
        enable = 0;
        cycle();
        chk("abort_out", duty_out, '0);
        chk("abort_upd", duty_upd, 1'b1);
        repeat (20) cycle();

        for (int ph = 0; ph < 8; ph++) begin
            reset = 1; enable = 0; target_valid = 0;
            period   = (ph == 3) ? 24'd5 : DW'($urandom_range(7, 60));
            duty_min = DW'($urandom_range(0, int'(period) + 5));
            step     = DW'($urandom_range(0, 12));
            repeat (2) cycle();
            reset = 0; enable = 1;
            for (int c = 0; c < 40 * int'(period) + 400; c++) begin
                target_valid = ($urandom_range(0, 7) == 0);
                if (target_valid)
                    for (int i = 0; i < NCH; i++)
                        target[i*DW +: DW] =
                            DW'($urandom_range(0, int'(period) + 10));
                if ($urandom_range(0, 499) == 0) enable = 0;
                else if (!enable && $urandom_range(0, 19) == 0) enable = 1;
                reset = ($urandom_range(0, 1999) == 0);
                cycle();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pwm_duty_sequencer.md
Name: pwm_duty_sequencer

Overview:
- Sequences duty updates for the four-channel motor PWM block: arming phase, slew-rate-limited ramping toward MCU targets, and atomic commit of all duties on PWM period boundaries.
- Sits between the MCU register file (period, targets) and the pwm_motor instances (time_work inputs).
- A single shared slew unit is time-multiplexed round-robin across channels after each period tick.

Parameters:
- DW, 24, width of period/duty values
- NCH, 4, number of motor channels
- ARM_PERIODS, 50, number of period ticks duty_out is held at duty_min before ramping
- WDOG_PERIODS, 25, ticks without target_valid before watchdog fault (optional feature only)

Ports:
- pwm_clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  level; 1 = arm/run, 0 = force idle
- period  in  DW  PWM period in clocks
- duty_min  in  DW  ESC idle/arming duty
- step  in  DW  max duty change per channel per period tick
- target  in  NCH*DW  requested duties, ch0 in LSBs
- target_valid  in  1  one-cycle strobe; latches target into shadow regs
- duty_out  out  NCH*DW  committed duties to pwm_motor time_work
- duty_upd  out  1  one-cycle pulse when duty_out changes
- armed  out  1  high in RUN state
- fault  out  1  watchdog fault flag (0 when feature is off)

Behaviour:
- Reset: state IDLE; duty_out=0; duty_upd=0; armed=0; fault=0; shadow and working regs=0; period counter=0.
- Period counter: counts 0..period-1 and wraps. tick=1 in the cycle count==period-1. When period<NCH+3 there are no ticks, counter held at 0, and duty_out keeps its current value.
- States:
  - IDLE: duty_out=0. Goes to ARM in the cycle after enable=1 is seen; counter restarts at 0.
  - ARM: duty_out=duty_min, committed with a duty_upd pulse on entry. After ARM_PERIODS ticks, goes to RUN with working duties = duty_min.
  - RUN: armed=1. On each tick, the snapshot of the shadow targets is taken and the sequencer walks ch0..chNCH-1, one channel per cycle, starting the cycle after the tick.
- Per channel (DW-bit unsigned arithmetic):
  - t = clamp(target_i, duty_min, period).
  - If |t-cur| <= step, cur=t; else cur = cur ± step toward t.
  - step=0 freezes all channels.
- Commit: once all channels are processed, duty_out is loaded with all working duties in a single cycle. duty_upd pulses in that same cycle, at tick+NCH+1. duty_out never shows a partial update.
- target_valid:
  - Writes the shadow regs at any time and in any state.
  - A strobe in the same cycle as tick is not in that tick's snapshot; it applies at the next tick.
  - Multiple strobes between ticks: last one wins.
- enable=0 in any state: next cycle is IDLE, duty_out=0, duty_upd pulses if duty_out was nonzero, and any in-flight sequence is aborted.
- reset mid-sequence: same values as power-on reset, no duty_upd pulse.
- duty_min>period: clamp to period (period wins).
- period changed mid-count: if the counter is already >= the new period-1, tick occurs next cycle and the counter wraps.

Optional Feature:
- Macro: PWM_SEQ_WATCHDOG_EN.
- With the macro:
  - In RUN, a tick counter resets on target_valid.
  - After WDOG_PERIODS ticks without a strobe, fault=1 and the shadow targets are forced to duty_min, so channels ramp down at step per tick.
  - fault clears only on reset or when going to IDLE.
- Without the macro: no counter, fault tied to 0, and the WDOG_PERIODS parameter is unused.

Decomposition:
- Package pwm_seq_pkg holds:
  - state enum (IDLE, ARM, RUN)
  - DW and NCH defaults
  - channel-index width constant
- Sub-module pwm_slew_step, the combinational clamp+slew unit:
  - inputs: cur, target, step, duty_min, period
  - output: next
  - one instance, shared by the round-robin sequencer.

Test Plan:
- Reset/idle: reset=1 for 3 cycles, enable=0 -> duty_out=0, armed=0, no duty_upd for 500 cycles.
- Arming: ARM_PERIODS=3, period=100, duty_min=10, enable=1 -> duty_out=10 on all channels; armed=1 after 3 ticks.
- Ramp: in RUN, step=4, target={40,10,12,100} -> ch0 goes 14,18,...,38,40 (one step per tick, duty_upd at tick+5); ch2 reaches 12 in a single tick; ch3 is clamped at period=100.
- Boundary: target_valid in the same cycle as tick with target=50 -> the following commit ignores 50 and the next commit uses it; target=5 with duty_min=10 -> holds at 10.
- Abort: enable=0 during the channel walk (tick+2) -> next cycle duty_out=0, IDLE, one duty_upd pulse, no later commit.
- Watchdog (macro on): WDOG_PERIODS=2, no strobes after reaching 40 with step=10 -> fault=1 after 2 ticks; ch0 goes 30,20,10, then holds at 10.
